// File: rtl/mem_dados_ws_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dados_pkg
//  Description : Shared encodings and lane helpers for the data memory
//                (size codes, FSM states, byte-enable mask, load extension,
//                alignment check).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_dados_pkg;

  // Access size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Handshake FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-lane enables for an access of the given size starting at byte offset
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] w_base;
    case (size)
      SZ_B:    w_base = 8'h01;
      SZ_H:    w_base = 8'h03;
      SZ_W:    w_base = 8'h0F;
      default: w_base = 8'hFF;
    endcase
    return w_base << off;
  endfunction

  // True when the offset is not a multiple of the access size
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic w_bad;
    case (size)
      SZ_B:    w_bad = 1'b0;
      SZ_H:    w_bad = off[0];
      SZ_W:    w_bad = |off[1:0];
      default: w_bad = |off;
    endcase
    return w_bad;
  endfunction

  // Truncate right-aligned load data to the access size and extend it
  function automatic logic [63:0] ld_extend(input logic [63:0] raw, input logic [1:0] size,
                                            input logic unsgn);
    logic [63:0] w_res;
    case (size)
      SZ_B:    w_res = {{56{~unsgn & raw[7]}},  raw[7:0]};
      SZ_H:    w_res = {{48{~unsgn & raw[15]}}, raw[15:0]};
      SZ_W:    w_res = {{32{~unsgn & raw[31]}}, raw[31:0]};
      default: w_res = raw;
    endcase
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dados_ws_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dados_ws_if
//  Description : Request/acknowledge bus between the CPU load/store unit
//                (master) and the data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_dados_ws_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
);
  logic                         req;
  logic                         we;
  logic [1:0]                   size;
  logic                         unsgn;
  logic [ADDR_WIDTH+OFF_W-1:0]  addr;
  logic [DATA_WIDTH-1:0]        data;
  logic [DATA_WIDTH-1:0]        q;
  logic                         ack;
  logic                         err;
  logic                         busy;

  modport master (
    output req, we, size, unsgn, addr, data,
    input  q, ack, err, busy
  );

  modport slave (
    input  req, we, size, unsgn, addr, data,
    output q, ack, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_dados_ws_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dados_array
//  Description : 2**ADDR_WIDTH x DATA_WIDTH RAM with per-byte write enables
//                and a registered, read-enabled output.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dados_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  wire logic                    clk,
  input  wire logic [ADDR_WIDTH-1:0]   i_addr,
  input  wire logic [DATA_WIDTH/8-1:0] i_be,
  input  wire logic [DATA_WIDTH-1:0]   i_wdata,
  input  wire logic                    i_re,
  output logic      [DATA_WIDTH-1:0]   o_rdata
);
  localparam int c_nb = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Byte-lane writes: disabled lanes keep their previous contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_nb; i++) begin
      if (i_be[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Registered read; output holds between read enables
  always_ff @(posedge clk) begin
    if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end
endmodule
`default_nettype wire

// File: rtl/mem_dados_ws.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dados_ws
//  Description : Data memory for the CPU load/store path. Request/ack
//                handshake with WAIT_STATES extra cycles, byte/half/word/
//                dword accesses, sign/zero-extended loads and misalignment
//                reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dados_ws
  import mem_dados_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1,
  parameter int OFF_W       = $clog2(DATA_WIDTH / 8)
) (
  input wire logic      clk,
  input wire logic      rst,
  mem_dados_ws_if.slave bus
);
  localparam int         c_nb = DATA_WIDTH / 8;
  localparam int         c_aw = ADDR_WIDTH + OFF_W;
  localparam logic [2:0] c_ws = 3'(WAIT_STATES);

  logic [1:0]            r_state;
  logic [2:0]            r_cnt;
  logic                  r_we;
  logic                  r_unsgn;
  logic [1:0]            r_size;
  logic [c_aw-1:0]       r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic                  r_q_zero;
  logic [1:0]            r_fmt_size;
  logic                  r_fmt_unsgn;
  logic [2:0]            r_fmt_off;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_we;
  logic                  w_unsgn;
  logic [1:0]            w_size;
  logic [c_aw-1:0]       w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [2:0]            w_off;
  logic                  w_bad;
  logic                  w_wr;
  logic                  w_rd;
  logic [c_nb-1:0]       w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_shift;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & bus.req;

  // With zero wait states the commit edge is the accept edge, so in IDLE the
  // access being decided is the one still on the bus; otherwise use the latch.
  assign w_we    = w_idle ? bus.we    : r_we;
  assign w_unsgn = w_idle ? bus.unsgn : r_unsgn;
  assign w_size  = w_idle ? bus.size  : r_size;
  assign w_addr  = w_idle ? bus.addr  : r_addr;
  assign w_data  = w_idle ? bus.data  : r_data;

  // Byte offset widened to the package helpers' 3-bit form
  always_comb begin
    w_off            = '0;
    w_off[OFF_W-1:0] = w_addr[OFF_W-1:0];
  end

  assign w_commit = (WAIT_STATES == 0) ? w_accept
                                       : ((r_state == ST_WAIT) && (r_cnt == 3'd1));
  assign w_bad    = misaligned(w_size, w_off) || ((w_size == SZ_D) && (DATA_WIDTH == 32));

  // A reset on the commit edge abandons the access: no write, no read
  assign w_wr    = w_commit & w_we & ~w_bad & ~rst;
  assign w_rd    = w_commit & ~w_we & ~w_bad & ~rst;
  assign w_be    = w_wr ? c_nb'(be_mask(w_size, w_off)) : '0;
  assign w_wdata = w_data << {w_off, 3'b000};

  mem_dados_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_addr  (w_addr[c_aw-1:OFF_W]),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .i_re    (w_rd),
    .o_rdata (w_rdata)
  );

  // Handshake FSM: accept in IDLE, count wait states, one-cycle RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt   <= c_ws;
            r_state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Latch the request at accept so later bus changes cannot disturb it
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= bus.we;
      r_unsgn <= bus.unsgn;
      r_size  <= bus.size;
      r_addr  <= bus.addr;
      r_data  <= bus.data;
    end
  end

  // Capture the response at the commit edge; stores leave q's format alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_q_zero    <= 1'b1;
      r_fmt_size  <= SZ_B;
      r_fmt_unsgn <= 1'b0;
      r_fmt_off   <= '0;
    end else if (w_commit) begin
      r_err <= w_bad;
      if (w_bad) begin
        r_q_zero <= 1'b1;
      end else if (!w_we) begin
        r_q_zero    <= 1'b0;
        r_fmt_size  <= w_size;
        r_fmt_unsgn <= w_unsgn;
        r_fmt_off   <= w_off;
      end
    end
  end

  // q is formed from the RAM output register and the captured format, so it
  // changes only at commit edges and holds between accesses.
  assign w_shift  = w_rdata >> {r_fmt_off, 3'b000};
  assign bus.q    = r_q_zero ? '0
                             : DATA_WIDTH'(ld_extend(64'(w_shift), r_fmt_size, r_fmt_unsgn));
  assign bus.ack  = (r_state == ST_RESP);
  assign bus.err  = r_err;
  assign bus.busy = ~w_idle;
endmodule
`default_nettype wire

// File: tb/tb_mem_dados_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_dados_ws
//  Description : Self-checking bench: two DUTs (WAIT_STATES=2 and 0) driven
//                with directed and random accesses against a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_dados_ws;
  import mem_dados_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst  [2];
  logic        d_req  [2];
  logic        d_we   [2];
  logic [1:0]  d_size [2];
  logic        d_uns  [2];
  logic [7:0]  d_addr [2];
  logic [31:0] d_data [2];
  logic [31:0] s_q    [2];
  logic        s_ack  [2];
  logic        s_err  [2];
  logic        s_busy [2];

  mem_dados_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .OFF_W(2)) bus0 ();
  mem_dados_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .OFF_W(2)) bus1 ();

  assign bus0.req = d_req[0];  assign bus1.req = d_req[1];
  assign bus0.we = d_we[0];    assign bus1.we = d_we[1];
  assign bus0.size = d_size[0]; assign bus1.size = d_size[1];
  assign bus0.unsgn = d_uns[0]; assign bus1.unsgn = d_uns[1];
  assign bus0.addr = d_addr[0]; assign bus1.addr = d_addr[1];
  assign bus0.data = d_data[0]; assign bus1.data = d_data[1];
  assign s_q[0] = bus0.q;       assign s_q[1] = bus1.q;
  assign s_ack[0] = bus0.ack;   assign s_ack[1] = bus1.ack;
  assign s_err[0] = bus0.err;   assign s_err[1] = bus1.err;
  assign s_busy[0] = bus0.busy; assign s_busy[1] = bus1.busy;

  mem_dados_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_STATES(2)) u_dut0 (
    .clk (clk), .rst (d_rst[0]), .bus (bus0)
  );
  mem_dados_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_STATES(0)) u_dut1 (
    .clk (clk), .rst (d_rst[1]), .bus (bus1)
  );

  int          errors = 0;
  int          checks = 0;
  int          ws_cfg [2] = '{2, 0};
  logic [7:0]  model  [2][256];
  logic [31:0] exp_q  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Little-endian byte-array read, truncated and extended per the size rules
  function automatic logic [31:0] model_load(input int s, input int a, input int sz, input bit uns);
    logic [63:0] v;
    logic [63:0] m;
    int n;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(model[s][a+i]) << (8*i));
    m = (64'd1 << (8*n)) - 64'd1;
    if (!uns && v[8*n-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // Present a request and pass the accept edge; afterwards scramble inputs
  task automatic start(input int s, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [7:0] a, input logic [31:0] dat);
    d_we[s] = we; d_size[s] = sz; d_uns[s] = uns; d_addr[s] = a; d_data[s] = dat;
    d_req[s] = 1'b1;
    @(posedge clk); #1;
    d_req[s]  = 1'b0;
    d_we[s]   = 1'($urandom_range(0, 1));
    d_size[s] = 2'($urandom_range(0, 3));
    d_uns[s]  = 1'($urandom_range(0, 1));
    d_addr[s] = 8'($urandom_range(0, 255));
    d_data[s] = $urandom;
  endtask

  task automatic access(input int s, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [7:0] a, input logic [31:0] dat, input string tag);
    bit bad;
    int lat;
    bad = (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00) || (sz == SZ_D);
    if (bad) exp_q[s] = '0;
    else if (we) for (int i = 0; i < (1 << sz); i++) model[s][int'(a)+i] = dat[8*i +: 8];
    else exp_q[s] = model_load(s, int'(a), int'(sz), uns);
    start(s, we, sz, uns, a, dat);
    lat = 0;
    while (s_ack[s] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat + 1), 32'(ws_cfg[s] + 1));
    chk({tag, "_err"}, 32'(s_err[s]), 32'(bad));
    chk({tag, "_q"}, s_q[s], exp_q[s]);
    @(posedge clk); #1;
    chk({tag, "_ack1"}, 32'(s_ack[s]), 32'd0);
    chk({tag, "_idle"}, 32'(s_busy[s]), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      d_rst[s] = 1'b1; d_req[s] = 1'b0; d_we[s] = 1'b0; d_size[s] = SZ_B;
      d_uns[s] = 1'b0; d_addr[s] = '0; d_data[s] = '0; exp_q[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_q", s_q[s], 32'd0);
      chk("rst_ack", 32'(s_ack[s]), 32'd0);
      chk("rst_err", 32'(s_err[s]), 32'd0);
      chk("rst_busy", 32'(s_busy[s]), 32'd0);
      d_rst[s] = 1'b0;
    end

    // Give every word a defined value in both memories
    for (int w = 0; w < 64; w++) begin
      access(0, 1'b1, SZ_W, 1'b0, 8'(w * 4), $urandom, "fill0");
      access(1, 1'b1, SZ_W, 1'b0, 8'(w * 4), $urandom, "fill1");
    end

    // Word store/load round trip
    access(0, 1'b1, SZ_W, 1'b0, 8'h10, 32'hDEADBEEF, "t1_st");
    access(0, 1'b0, SZ_W, 1'b0, 8'h10, 32'h0, "t1_ld");
    chk("t1_val", s_q[0], 32'hDEADBEEF);

    // Byte store into one lane, then signed/unsigned byte loads
    access(0, 1'b1, SZ_B, 1'b0, 8'h11, 32'h0000007F, "t2_st");
    access(0, 1'b0, SZ_W, 1'b0, 8'h10, 32'h0, "t2_ldw");
    chk("t2_word", s_q[0], 32'hDEAD7FEF);
    access(0, 1'b0, SZ_B, 1'b0, 8'h13, 32'h0, "t2_lbs");
    chk("t2_lbs_val", s_q[0], 32'hFFFFFFDE);
    access(0, 1'b0, SZ_B, 1'b1, 8'h13, 32'h0, "t2_lbu");
    chk("t2_lbu_val", s_q[0], 32'h000000DE);

    // Half loads: aligned sign-extended, then misaligned
    access(0, 1'b0, SZ_H, 1'b0, 8'h12, 32'h0, "t3_lh");
    chk("t3_lh_val", s_q[0], 32'hFFFFDEAD);
    access(0, 1'b0, SZ_H, 1'b0, 8'h11, 32'h0, "t3_mis");
    chk("t3_mis_q", s_q[0], 32'h0);
    access(0, 1'b1, SZ_H, 1'b0, 8'h13, 32'hFFFF1234, "t3_mis_st");
    access(0, 1'b0, SZ_W, 1'b0, 8'h10, 32'h0, "t3_reread");
    chk("t3_reread_val", s_q[0], 32'hDEAD7FEF);

    // Random traffic, biased towards aligned addresses
    for (int n = 0; n < 150; n++) begin
      logic [1:0] sz;
      logic [7:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
      access(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end

    // Zero wait states: req held high gives ack every second cycle
    exp_q[1] = model_load(1, 0, 2, 1'b0);
    d_we[1] = 1'b0; d_size[1] = SZ_W; d_uns[1] = 1'b0; d_addr[1] = 8'h00; d_req[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("t4_ack", 32'(s_ack[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t4_busy", 32'(s_busy[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk("t4_q", s_q[1], exp_q[1]);
    end
    d_req[1] = 1'b0;
    @(posedge clk); #1;
    access(1, 1'b1, SZ_D, 1'b0, 8'h08, 32'h55AA55AA, "t4_dw");
    access(1, 1'b0, SZ_W, 1'b0, 8'h08, 32'h0, "t4_dw_chk");

    // Reset during WAIT abandons the store
    start(0, 1'b1, SZ_W, 1'b0, 8'h20, 32'h12345678);
    d_rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("t5_ack", 32'(s_ack[0]), 32'd0);
    chk("t5_busy", 32'(s_busy[0]), 32'd0);
    chk("t5_q", s_q[0], 32'd0);
    d_rst[0] = 1'b0;
    exp_q[0] = '0;
    access(0, 1'b0, SZ_W, 1'b0, 8'h20, 32'h0, "t5_ld");

    // Reset exactly on the commit edge also suppresses the write
    start(0, 1'b1, SZ_W, 1'b0, 8'h20, 32'h12345678);
    @(posedge clk); #1;
    d_rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("t5b_ack", 32'(s_ack[0]), 32'd0);
    chk("t5b_busy", 32'(s_busy[0]), 32'd0);
    d_rst[0] = 1'b0;
    exp_q[0] = '0;
    access(0, 1'b0, SZ_W, 1'b0, 8'h20, 32'h0, "t5b_ld");

    // Inputs scrambled during WAIT must not affect the store in flight
    access(0, 1'b1, SZ_W, 1'b0, 8'h04, 32'hA5A5A5A5, "t6_st");
    access(0, 1'b0, SZ_W, 1'b0, 8'h04, 32'h0, "t6_ld");
    chk("t6_val", s_q[0], 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_dados_ws.md
Name: mem_dados_ws

Overview:
- Parametrised data memory for the CPU load/store path, with a request/acknowledge handshake.
- Supports byte, half, word and (optionally) double-word accesses through byte-lane write strobes.
- Loads return sign- or zero-extended sub-word data.
- Misaligned accesses are detected and reported; a configurable number of wait states models slower memory.

Parameters:
- DATA_WIDTH, 32: word width in bits. Legal values are 32 and 64.
- ADDR_WIDTH, 6: word-address bits. Depth is 2**ADDR_WIDTH words.
- WAIT_STATES, 1: extra cycles between accept and response. Legal range 0..7.
- OFF_W, $clog2(DATA_WIDTH/8): byte-offset bits. Derived; must not be overridden.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  request valid; held high by the master until ack.
- we  in  1  1 = store, 0 = load; sampled at accept.
- size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_WIDTH=64).
- unsgn  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_WIDTH+OFF_W  byte address.
- data  in  DATA_WIDTH  store data, right-aligned (low bits).
- q  out  DATA_WIDTH  load result; registered.
- ack  out  1  one-cycle response pulse.
- err  out  1  qualified by ack; 1 = misaligned or illegal size.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, wait counter=0, q=0, ack=0, err=0, busy=0.
  - RAM contents are not initialised or cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req=1 at posedge means accept. Latch we, size, unsgn, addr and data. Go to WAIT, or straight to RESP if WAIT_STATES=0. Counter is loaded with WAIT_STATES.
  - WAIT: decrement the counter each cycle. Go to RESP on the cycle the counter reaches 1.
  - RESP: ack=1 for exactly this cycle, then return to IDLE unconditionally.
- Latency: ack is asserted WAIT_STATES+1 cycles after the accept edge.
  - Minimum request spacing is WAIT_STATES+2 cycles; there is one IDLE bubble after every ack.
- Commit point: stores write the RAM at the posedge that enters RESP. q and err are registered at that same edge.
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Dword requires addr[2:0]=0.
  - Byte is always aligned.
  - Violation, or size=11 with DATA_WIDTH=32: no RAM write, q=0, err=1 with ack.
- Store lanes: the byte-enable mask is derived from size and the offset. data is shifted left by 8*offset. Only enabled byte lanes change; other lanes keep their old contents.
- Load: the word at addr[ADDR_WIDTH+OFF_W-1:OFF_W] is shifted right by 8*offset and truncated to the access size. It is then extended per unsgn. For full-width loads, unsgn is ignored.
- q holds its last value between accesses. It is updated only on a load ack or an error ack. A successful store ack leaves q unchanged.
- Changes to inputs after accept have no effect on the access in flight.
- req low during WAIT or RESP is ignored; the access still completes.
- Reset mid-operation: the access is abandoned. If rst is high at the commit edge, no write occurs. ack is not asserted for an abandoned access.
- Read-after-write to the same address, issued after the ack, returns the new data.
- Out-of-range addresses cannot occur; the full address space is decoded.

Decomposition:
- Package mem_dados_pkg contains:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - state encoding ST_IDLE, ST_WAIT, ST_RESP;
  - functions for byte-enable mask generation and load extension.
- Sub-module mem_dados_array:
  - RAM of 2**ADDR_WIDTH x DATA_WIDTH;
  - per-byte write enable on posedge clk;
  - registered read.
- mem_dados_ws keeps the FSM, the alignment check and the lane steering.

Test Plan (DATA_WIDTH=32, WAIT_STATES=2 unless stated):
1. Store word 0xDEADBEEF at 0x10, then load word at 0x10. Store ack arrives 3 cycles after accept with err=0; load returns q=0xDEADBEEF.
2. Store byte 0x7F at 0x11. Load word at 0x10 returns q=0xDEAD7FEF.
   - Load byte at 0x13 with unsgn=0 returns q=0xFFFFFFDE.
   - Load byte at 0x13 with unsgn=1 returns q=0x000000DE.
3. Load half at 0x12 with unsgn=0 returns q=0xFFFFDEAD. Load half at 0x11 gives ack with err=1 and q=0; RAM is unchanged when re-read.
4. WAIT_STATES=0: back-to-back req held high gives ack every 2nd cycle, busy=1 on the non-IDLE cycles. Store word with size=11 gives err=1 and no write.
5. Store word 0x12345678 at 0x20 with rst pulsed in the WAIT state. Then ack=0 and busy=0 next cycle, and a later load at 0x20 returns the old contents.
6. Change data/addr during WAIT after a store of 0xA5A5A5A5 to 0x04. Location 0x04 holds 0xA5A5A5A5; the new inputs are ignored.
